// File: rtl/var_shift_tx.sv
// var_shift_tx: parallel-in/serial-out transmitter, MSB- or LSB-first per word, back-to-back capable.
// Optional trailing even-parity bit when VAR_SHIFT_TX_PARITY_EN is defined.
module var_shift_tx #(
   parameter int N  = 32,
   localparam int CW = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] load_data,
   input  logic         dir,
   output logic         sout,
   output logic         sout_valid,
   output logic         busy,
   output logic         done
);
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
   state_t         r_state, w_next;
   logic [N-1:0]   r_sreg;
   logic [CW-1:0]  r_cnt;
   logic           r_ord;
   logic           r_done;
   logic           w_acc;
   logic           w_last_data;
   logic           w_last;
   logic           w_sbit;
   assign w_last_data = (r_state == S_SHIFT) && (r_cnt == CW'(1));
   assign w_sbit      = r_ord ? r_sreg[N-1] : r_sreg[0];
`ifdef VAR_SHIFT_TX_PARITY_EN
   logic r_par;
   assign w_last = (r_state == S_PAR);
   always_ff @(posedge clk or negedge clr)
      if (!clr) r_par <= 1'b0;
      else if (w_acc) r_par <= ^load_data;
   assign sout = (r_state == S_SHIFT) ? w_sbit : (r_state == S_PAR) ? r_par : 1'b0;
`else
   assign w_last = w_last_data;
   assign sout   = (r_state == S_SHIFT) ? w_sbit : 1'b0;
`endif
   assign load_ready = (r_state == S_IDLE) || w_last;
   assign w_acc      = load_valid && load_ready;
   assign sout_valid = (r_state != S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign done       = r_done;
   always_comb begin
      w_next = r_state;
      if (w_acc) w_next = S_SHIFT;
`ifdef VAR_SHIFT_TX_PARITY_EN
      else if (w_last_data) w_next = S_PAR;
`endif
      else if (w_last) w_next = S_IDLE;
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= S_IDLE;
         r_sreg  <= '0;
         r_cnt   <= '0;
         r_ord   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_last;
         if (w_acc) begin
            r_sreg <= load_data;
            r_ord  <= dir;
            r_cnt  <= CW'(N);
         end else if (r_state == S_SHIFT) begin
            r_sreg <= r_ord ? {r_sreg[N-2:0], 1'b0} : {1'b0, r_sreg[N-1:1]};
            r_cnt  <= r_cnt - CW'(1);
         end
      end
   end
   // the counter must only ever reach zero by leaving SHIFT on the last data bit
   a_cnt_no_wrap: assert property (@(posedge clk) disable iff (!clr) (r_state == S_SHIFT) |-> (r_cnt != '0));
endmodule

// File: tb/tb_var_shift_tx.sv
// tb_var_shift_tx: directed table-driven bench for var_shift_tx with N=8.
// Parity frames are checked when VAR_SHIFT_TX_PARITY_EN is defined.
module tb_var_shift_tx;
   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic [7:0] load_data = '0;
   logic       dir = 1'b0;
   logic       sout, sout_valid, busy, done;
   int         total = 0;
   int         bad = 0;
   typedef struct {
      logic [7:0] d;
      logic       dr;
      logic [7:0] seq;
   } vec_t;
   vec_t tv[6];

   var_shift_tx #(.N(8)) dut (
      .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .dir(dir), .sout(sout), .sout_valid(sout_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // called at a negedge with the transmitter idle; returns at a negedge
   task automatic send(input logic [7:0] d, input logic dr, input logic [7:0] seq);
      load_valid = 1'b1;
      load_data  = d;
      dir        = dr;
      @(posedge clk);
      @(negedge clk);
      load_valid = 1'b0;
      load_data  = 8'hxx;
      dir        = 1'bx;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("sout d=%h dir=%0d bit%0d", d, dr, k), 16'(sout), 16'(seq[7-k]));
         chk($sformatf("sout_valid bit%0d", k), 16'(sout_valid), 16'd1);
`ifdef VAR_SHIFT_TX_PARITY_EN
         chk($sformatf("load_ready bit%0d", k), 16'(load_ready), 16'd0);
`else
         chk($sformatf("load_ready bit%0d", k), 16'(load_ready), 16'(k == 7));
`endif
         @(negedge clk);
      end
`ifdef VAR_SHIFT_TX_PARITY_EN
      chk($sformatf("parity d=%h", d), 16'(sout), 16'(^d));
      chk("parity valid", 16'(sout_valid), 16'd1);
      chk("parity load_ready", 16'(load_ready), 16'd1);
      @(negedge clk);
`endif
      chk($sformatf("done d=%h", d), 16'(done), 16'd1);
      chk("idle after frame", {14'd0, sout_valid, busy}, 16'd0);
      @(negedge clk);
      chk("done one-shot", 16'(done), 16'd0);
   endtask

   initial begin
      tv[0] = '{8'hA5, 1'b1, 8'hA5};
      tv[1] = '{8'hA5, 1'b0, 8'hA5};
      tv[2] = '{8'h01, 1'b0, 8'h80};
      tv[3] = '{8'h01, 1'b1, 8'h01};
      tv[4] = '{8'h80, 1'b0, 8'h01};
      tv[5] = '{8'h1E, 1'b0, 8'h78};
      repeat (2) @(negedge clk);
      chk("reset outputs", {12'd0, sout, sout_valid, busy, done}, 16'd0);
      chk("reset load_ready", 16'(load_ready), 16'd1);
      clr = 1'b1;
      @(negedge clk);
      chk("idle outputs", {12'd0, sout, sout_valid, busy, done}, 16'd0);
      chk("idle load_ready", 16'(load_ready), 16'd1);
      for (int i = 0; i < 6; i++) send(tv[i].d, tv[i].dr, tv[i].seq);
`ifndef VAR_SHIFT_TX_PARITY_EN
      begin
         logic [15:0] exp_b2b = 16'hF00F;
         load_valid = 1'b1;
         load_data  = 8'hF0;
         dir        = 1'b1;
         @(posedge clk);
         @(negedge clk);
         load_data = 8'h0F;
         for (int k = 0; k < 16; k++) begin
            chk($sformatf("b2b sout c%0d", k + 1), 16'(sout), 16'(exp_b2b[15-k]));
            chk($sformatf("b2b valid c%0d", k + 1), 16'(sout_valid), 16'd1);
            chk($sformatf("b2b ready c%0d", k + 1), 16'(load_ready), 16'(k == 7 || k == 15));
            chk($sformatf("b2b done c%0d", k + 1), 16'(done), 16'(k == 8));
            if (k == 15) load_valid = 1'b0;
            @(negedge clk);
         end
         chk("b2b final done", 16'(done), 16'd1);
         chk("b2b idle", 16'(sout_valid), 16'd0);
         @(negedge clk);
      end
`else
      send(8'h07, 1'b1, 8'h07);
`endif
      load_valid = 1'b1;
      load_data  = 8'hFF;
      dir        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre-reset bit3", {14'd0, sout, sout_valid}, 16'd3);
      clr = 1'b0;
      #1;
      chk("async reset outputs", {12'd0, sout, sout_valid, busy, done}, 16'd0);
      chk("async reset ready", 16'(load_ready), 16'd1);
      @(negedge clk);
      clr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("no done after reset c%0d", k), {14'd0, done, sout_valid}, 16'd0);
         @(negedge clk);
      end
      send(8'hC3, 1'b1, 8'hC3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
